// File: rtl/add_sub_div.sv
// Unsigned restoring divider, one trial subtraction per cycle.
// Define DIV_ZERO_CHK_EN for a 1-cycle divide-by-zero path with err.
module add_sub_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rem, quo, bd;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sh, diff;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic             accept, last;
`ifdef DIV_ZERO_CHK_EN
  logic             zf;
`endif

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Shifted partial remainder always fits WIDTH+1 bits since rem < b.
  always_comb begin
    sh    = {rem, quo[WIDTH-1]};
    diff  = sh - {1'b0, bd};
    rem_n = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      bd  <= '0;
      cnt <= '0;
      q   <= '0;
      r   <= '0;
      err <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
      zf  <= 1'b0;
`endif
    end else if (accept) begin
      quo <= a;
      bd  <= b;
      rem <= '0;
      cnt <= CW'(WIDTH);
`ifdef DIV_ZERO_CHK_EN
      zf  <= (b == '0);
      // Park the dividend in rem and finish after a single cycle.
      if (b == '0) begin
        rem <= a;
        cnt <= CW'(1);
      end
`endif
    end else if (state == RUN) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt - CW'(1);
      if (last) begin
        q   <= quo_n;
        r   <= rem_n;
        err <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
        if (zf) begin
          q   <= '1;
          r   <= rem;
          err <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_add_sub_div.sv
// Bench for add_sub_div: directed table, random vectors vs model,
// and hand sequences for restart, reset and back-to-back cases.
module tb_add_sub_div;

  localparam int W = 4;
`ifdef DIV_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] a, b, q, r;
  logic         busy, done, err;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  add_sub_div #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] ta, tb,
                       output logic [W-1:0] eq, er,
                       output bit ee, output int el);
    if (tb == 0) begin
      eq = '1;
      er = ta;
    end else begin
      eq = W'(int'(ta) / int'(tb));
      er = W'(int'(ta) % int'(tb));
    end
    ee = ZCHK && (tb == 0);
    el = ee ? 2 : W + 1;
  endtask

  task automatic run_div(input logic [W-1:0] ta, tb,
                         input logic [W-1:0] xq, xr,
                         input string nm);
    logic [W-1:0] eq, er;
    bit ee;
    int el, k;
    model(ta, tb, eq, er, ee, el);
    chk({nm, " model_q"}, int'(xq), int'(eq));
    chk({nm, " model_r"}, int'(xr), int'(er));
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk({nm, " busy"}, int'(busy), 1);
    chk({nm, " q_hold"}, int'(q), int'(prev_q));
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, el);
    chk({nm, " done"}, int'(done), 1);
    chk({nm, " q"}, int'(q), int'(eq));
    chk({nm, " r"}, int'(r), int'(er));
    chk({nm, " err"}, int'(err), int'(ee));
    prev_q = eq;
    prev_r = er;
    @(negedge clk);
    chk({nm, " done_drop"}, int'(done), 0);
  endtask

  initial begin
    vec_t vt[6];
    logic [W-1:0] ra, rb, eq, er;
    bit ee;
    int el, k, nd, lastd;

    vt[0] = '{4'd13, 4'd3, 4'd4, 4'd1};
    vt[1] = '{4'd15, 4'd1, 4'd15, 4'd0};
    vt[2] = '{4'd3, 4'd7, 4'd0, 4'd3};
    vt[3] = '{4'd8, 4'd8, 4'd1, 4'd0};
    vt[4] = '{4'd9, 4'd0, 4'd15, 4'd9};
    vt[5] = '{4'd0, 4'd5, 4'd0, 4'd0};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("rst q", int'(q), 0);
    chk("rst r", int'(r), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst err", int'(err), 0);
    rst_n = 1'b1;

    foreach (vt[i])
      run_div(vt[i].a, vt[i].b, vt[i].q, vt[i].r,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(ra, rb, eq, er, ee, el);
      run_div(ra, rb, eq, er, $sformatf("rnd%0d", i));
    end

    // Second start two cycles into a run must be ignored.
    @(negedge clk);
    start = 1'b1;
    a = 4'd14;
    b = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a = 4'd1;
    b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    k = 3;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ign latency", k, W + 1);
    chk("ign q", int'(q), 3);
    chk("ign r", int'(r), 2);
    @(negedge clk);
    chk("ign idle", int'(busy | done), 0);

    // Reset mid-run, with a start presented during reset.
    @(negedge clk);
    start = 1'b1;
    a = 4'd13;
    b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    a = 4'd5;
    b = 4'd1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    chk("mrst q", int'(q), 0);
    chk("mrst r", int'(r), 0);
    chk("mrst busy", int'(busy), 0);
    chk("mrst done", int'(done), 0);
    chk("mrst err", int'(err), 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("mrst quiet", nd, 0);
    prev_q = '0;
    prev_r = '0;
    run_div(4'd13, 4'd3, 4'd4, 4'd1, "post_rst");

    // Start held high: one result every WIDTH+1 cycles.
    @(negedge clk);
    start = 1'b1;
    a = 4'd7;
    b = 4'd2;
    nd = 0;
    lastd = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk($sformatf("b2b gap%0d", nd), i - lastd, W + 1);
        chk($sformatf("b2b q%0d", nd), int'(q), 3);
        chk($sformatf("b2b r%0d", nd), int'(r), 1);
        lastd = i;
      end
    end
    start = 1'b0;
    chk("b2b count", nd, 3);
    repeat (2) @(negedge clk);
    chk("b2b idle", int'(busy | done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
